kbd_event_ctrl: RTL and testbench

Keyboard event controller between the PS/2 byte receiver and the text-editing core. It consumes PS/2 set-2 scan-code bytes, tracks make/break, extended-prefix and modifier state (Shift, Caps Lock), and translates make codes to ASCII through a scan-code lookup. Resulting characters are queued in a small FIFO and drained by the editor over a valid/ready handshake.

---
 rtl/kbd_pkg.sv | 62 ++++++
 rtl/scan_ascii_lut.sv | 52 +++++
 rtl/kbd_event_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_kbd_event_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard event controller: decoder
// states, PS/2 set-2 prefix and modifier codes, and editor codes for the
// extended cursor/delete keys.
package kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } kbd_state_e;

   // Prefix bytes
   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   // Modifier make/break codes
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_ALT    = 8'h11;

   // Extended (0xE0-prefixed) keys that reach the editor
   localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
   localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
   localparam logic [7:0] SC_EXT_UP    = 8'h75;
   localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
   localparam logic [7:0] SC_EXT_DEL   = 8'h71;

   // Editor codes produced for those keys
   localparam logic [7:0] ASC_DEL   = 8'h7F;
   localparam logic [7:0] ASC_LEFT  = 8'h80;
   localparam logic [7:0] ASC_RIGHT = 8'h81;
   localparam logic [7:0] ASC_UP    = 8'h82;
   localparam logic [7:0] ASC_DOWN  = 8'h83;

   // Keyboard status/ack bytes that carry no key information in IDLE.
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
             (b == 8'hFE) || (b == 8'hE1);
   endfunction

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
   endfunction

   // Extended make code to editor code; 0x00 means the key is dropped.
   function automatic logic [7:0] ext_to_ascii(input logic [7:0] code);
      logic [7:0] r;
      case (code)
         SC_EXT_LEFT:  r = ASC_LEFT;
         SC_EXT_RIGHT: r = ASC_RIGHT;
         SC_EXT_UP:    r = ASC_UP;
         SC_EXT_DOWN:  r = ASC_DOWN;
         SC_EXT_DEL:   r = ASC_DEL;
         default:      r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/scan_ascii_lut.sv
// Combinational PS/2 set-2 make code to ASCII translation (US layout).
// Unmapped codes, including the numeric keypad and function keys, give 0x00.
module scan_ascii_lut (
   input  logic [7:0] code_i,
   input  logic       shift_i,
   output logic [7:0] ascii_o
);

   logic [7:0] lo;
   logic [7:0] hi;

   // Look up the unshifted/shifted character pair for the code.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      lo = 8'h00;
      hi = 8'h00;
      case (code_i)
         8'h1C: {lo, hi} = "aA";   8'h32: {lo, hi} = "bB";
         8'h21: {lo, hi} = "cC";   8'h23: {lo, hi} = "dD";
         8'h24: {lo, hi} = "eE";   8'h2B: {lo, hi} = "fF";
         8'h34: {lo, hi} = "gG";   8'h33: {lo, hi} = "hH";
         8'h43: {lo, hi} = "iI";   8'h3B: {lo, hi} = "jJ";
         8'h42: {lo, hi} = "kK";   8'h4B: {lo, hi} = "lL";
         8'h3A: {lo, hi} = "mM";   8'h31: {lo, hi} = "nN";
         8'h44: {lo, hi} = "oO";   8'h4D: {lo, hi} = "pP";
         8'h15: {lo, hi} = "qQ";   8'h2D: {lo, hi} = "rR";
         8'h1B: {lo, hi} = "sS";   8'h2C: {lo, hi} = "tT";
         8'h3C: {lo, hi} = "uU";   8'h2A: {lo, hi} = "vV";
         8'h1D: {lo, hi} = "wW";   8'h22: {lo, hi} = "xX";
         8'h35: {lo, hi} = "yY";   8'h1A: {lo, hi} = "zZ";
         8'h16: {lo, hi} = "1!";   8'h1E: {lo, hi} = "2@";
         8'h26: {lo, hi} = "3#";   8'h25: {lo, hi} = "4$";
         8'h2E: {lo, hi} = "5%";   8'h36: {lo, hi} = "6^";
         8'h3D: {lo, hi} = "7&";   8'h3E: {lo, hi} = "8*";
         8'h46: {lo, hi} = "9(";   8'h45: {lo, hi} = "0)";
         8'h0E: {lo, hi} = "`~";   8'h4E: {lo, hi} = "-_";
         8'h55: {lo, hi} = "=+";   8'h54: {lo, hi} = "[{";
         8'h5B: {lo, hi} = "]}";   8'h5D: {lo, hi} = "\\|";
         8'h4C: {lo, hi} = ";:";   8'h52: {lo, hi} = "'\"";
         8'h41: {lo, hi} = ",<";   8'h49: {lo, hi} = ".>";
         8'h4A: {lo, hi} = "/?";   8'h29: {lo, hi} = "  ";
         8'h5A: {lo, hi} = 16'h0D0D;  // Enter
         8'h66: {lo, hi} = 16'h0808;  // Backspace
         8'h0D: {lo, hi} = 16'h0909;  // Tab
         8'h76: {lo, hi} = 16'h1B1B;  // Escape
         default: {lo, hi} = 16'h0000;
      endcase
   end

   assign ascii_o = shift_i ? hi : lo;

endmodule

// File: rtl/kbd_event_ctrl.sv
// Keyboard event controller: decodes PS/2 set-2 byte streams into make/break
// events, tracks Shift/Caps Lock, translates make codes to ASCII and queues
// the characters in a FIFO drained over a valid/ready handshake.
module kbd_event_ctrl
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] ps2_data,
   input  logic       ps2_ready,
   output logic [7:0] ascii_data,
   output logic       ascii_valid,
   input  logic       ascii_ready,
   output logic       shift_o,
   output logic       caps_o,
   output logic       key_down,
   output logic [7:0] cur_code,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   kbd_state_e state_q, state_d;

   logic ev_make, ev_ext_make, ev_brk;

   logic       lshift_q, lshift_d;
   logic       rshift_q, rshift_d;
   logic       caps_q, caps_d;
   logic       caps_held_q, caps_held_d;
   logic       key_down_q, key_down_d;
   logic [7:0] cur_code_q, cur_code_d;
   logic       overflow_q;

   logic [7:0] lut_ascii;
   logic [7:0] push_char;
   logic       push_req;

   logic [7:0]  fifo_mem_q [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   logic        fifo_empty, fifo_full, do_push, do_pop;

   // ------------------------------------------------------------------
   // Prefix decoder FSM
   // ------------------------------------------------------------------

   // State register.
   always_ff @(posedge clk or negedge clrn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!clrn) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: prefixes steer, any other byte ends the sequence.
   always_comb begin
      state_d = state_q;
      if (ps2_ready) begin
         unique case (state_q)
            ST_IDLE: begin
               if (ps2_data == PFX_EXT)      state_d = ST_EXT;
               else if (ps2_data == PFX_BRK) state_d = ST_BRK;
            end
            ST_EXT:     state_d = (ps2_data == PFX_BRK) ? ST_EXT_BRK : ST_IDLE;
            ST_BRK:     state_d = ST_IDLE;
            ST_EXT_BRK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Event strobes: which kind of key code the current byte completes.
   always_comb begin
      ev_make     = 1'b0;
      ev_ext_make = 1'b0;
      ev_brk      = 1'b0;
      if (ps2_ready) begin
         unique case (state_q)
            ST_IDLE:    ev_make = (ps2_data != PFX_EXT) && (ps2_data != PFX_BRK) &&
                                  !is_status_byte(ps2_data);
            ST_EXT:     ev_ext_make = (ps2_data != PFX_BRK);
            ST_BRK:     ev_brk = 1'b1;
            ST_EXT_BRK: ev_brk = 1'b1;
            default:    ev_brk = 1'b0;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Translation and modifier tracking
   // ------------------------------------------------------------------

   // Shift seen by the LUT is the registered state, so a modifier byte only
   // affects bytes that follow it.
   scan_ascii_lut u_lut (
      .code_i  (ps2_data),
      .shift_i (shift_o),
      .ascii_o (lut_ascii)
   );

   // Apply make/break events to modifier and key state; form the push request.
   always_comb begin
      lshift_d    = lshift_q;
      rshift_d    = rshift_q;
      caps_d      = caps_q;
      caps_held_d = caps_held_q;
      key_down_d  = key_down_q;
      cur_code_d  = cur_code_q;
      push_char   = 8'h00;
      push_req    = 1'b0;

      if (ev_make) begin
         case (ps2_data)
            SC_LSHIFT: lshift_d = 1'b1;
            SC_RSHIFT: rshift_d = 1'b1;
            SC_CAPS: begin
               // Typematic repeats of Caps Lock arrive while held; toggle once.
               if (!caps_held_q) caps_d = ~caps_q;
               caps_held_d = 1'b1;
            end
            SC_CTRL, SC_ALT: ;
            default: begin
               cur_code_d = ps2_data;
               key_down_d = 1'b1;
               push_char  = (caps_q && is_letter(lut_ascii)) ? (lut_ascii ^ 8'h20) : lut_ascii;
               push_req   = (push_char != 8'h00);
            end
         endcase
      end

      if (ev_ext_make && (ext_to_ascii(ps2_data) != 8'h00)) begin
         cur_code_d = ps2_data;
         key_down_d = 1'b1;
         push_char  = ext_to_ascii(ps2_data);
         push_req   = 1'b1;
      end

      if (ev_brk) begin
         if (ps2_data == SC_LSHIFT) lshift_d = 1'b0;
         if (ps2_data == SC_RSHIFT) rshift_d = 1'b0;
         if (ps2_data == SC_CAPS)   caps_held_d = 1'b0;
         if (ps2_data == cur_code_q) key_down_d = 1'b0;
      end
   end

   // Modifier and key-status registers.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         caps_q      <= 1'b0;
         caps_held_q <= 1'b0;
         key_down_q  <= 1'b0;
         cur_code_q  <= 8'h00;
      end else begin
         lshift_q    <= lshift_d;
         rshift_q    <= rshift_d;
         caps_q      <= caps_d;
         caps_held_q <= caps_held_d;
         key_down_q  <= key_down_d;
         cur_code_q  <= cur_code_d;
      end
   end

   // ------------------------------------------------------------------
   // Character FIFO
   // ------------------------------------------------------------------

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop     = !fifo_empty && ascii_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push    = push_req && (!fifo_full || do_pop);

   // Pointers and the sticky drop flag.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push_req && !do_push) overflow_q <= 1'b1;
      end
   end

   // Storage array.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; empty pointers make stale entries unreachable and the head is masked below.
      if (do_push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= push_char;
   end

   assign ascii_valid = !fifo_empty;
   assign ascii_data  = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q[AW-1:0]];
   assign shift_o     = lshift_q | rshift_q;
   assign caps_o      = caps_q;
   assign key_down    = key_down_q;
   assign cur_code    = cur_code_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Self-checking bench for kbd_event_ctrl: directed scenarios plus random
// byte streams compared every cycle against a behavioural keyboard model.
module tb_kbd_event_ctrl;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       clrn = 1'b0;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_ready = 1'b0;
   logic [7:0] ascii_data;
   logic       ascii_valid;
   logic       ascii_ready = 1'b0;
   logic       shift_o, caps_o, key_down, overflow;
   logic [7:0] cur_code;

   int n_total = 0;
   int n_bad   = 0;

   kbd_event_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .clrn        (clrn),
      .ps2_data    (ps2_data),
      .ps2_ready   (ps2_ready),
      .ascii_data  (ascii_data),
      .ascii_valid (ascii_valid),
      .ascii_ready (ascii_ready),
      .shift_o     (shift_o),
      .caps_o      (caps_o),
      .key_down    (key_down),
      .cur_code    (cur_code),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                     8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                     8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                     8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
                                    8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
   string digit_plain = "1234567890";
   string digit_shift = "!@#$%^&*()";

   logic [7:0] exp_q [$];
   bit         m_ext, m_brk, m_lsh, m_rsh, m_caps, m_caps_held, m_key, m_ovf;
   logic [7:0] m_cur;

   // Character typed for a plain make code; case follows Shift XOR Caps for letters.
   function automatic logic [7:0] model_char(input logic [7:0] code, input bit sh, input bit cp);
      for (int i = 0; i < 26; i++)
         if (letter_codes[i] == code) return ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i);
      for (int i = 0; i < 10; i++)
         if (digit_codes[i] == code) return sh ? digit_shift[i] : digit_plain[i];
      if (code == 8'h29) return 8'h20;
      return 8'h00;
   endfunction

   function automatic logic [7:0] model_ext(input logic [7:0] code);
      case (code)
         8'h6B: return 8'h80;
         8'h74: return 8'h81;
         8'h75: return 8'h82;
         8'h72: return 8'h83;
         8'h71: return 8'h7F;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      exp_q.delete();
      {m_ext, m_brk, m_lsh, m_rsh, m_caps, m_caps_held, m_key, m_ovf} = '0;
      m_cur = 8'h00;
   endtask

   task automatic model_push(input logic [7:0] c);
      if (exp_q.size() < DEPTH) exp_q.push_back(c);
      else m_ovf = 1'b1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [7:0] c;
      if (m_brk) begin
         if (b == 8'h12) m_lsh = 1'b0;
         if (b == 8'h59) m_rsh = 1'b0;
         if (b == 8'h58) m_caps_held = 1'b0;
         if (b == m_cur) m_key = 1'b0;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1'b1;
         else begin
            c = model_ext(b);
            if (c != 8'h00) begin
               m_cur = b;
               m_key = 1'b1;
               model_push(c);
            end
            m_ext = 1'b0;
         end
      end else if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else if (b inside {8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hE1, 8'h14, 8'h11}) begin
      end else if (b == 8'h12) m_lsh = 1'b1;
      else if (b == 8'h59) m_rsh = 1'b1;
      else if (b == 8'h58) begin
         if (!m_caps_held) m_caps = !m_caps;
         m_caps_held = 1'b1;
      end else begin
         m_cur = b;
         m_key = 1'b1;
         c = model_char(b, m_lsh || m_rsh, m_caps);
         if (c != 8'h00) model_push(c);
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("valid",    ascii_valid, exp_q.size() != 0);
      chk("data",     ascii_data,  (exp_q.size() != 0) ? exp_q[0] : 8'h00);
      chk("shift",    shift_o,     m_lsh || m_rsh);
      chk("caps",     caps_o,      m_caps);
      chk("key_down", key_down,    m_key);
      chk("cur_code", cur_code,    m_cur);
      chk("overflow", overflow,    m_ovf);
   endtask

   // One clock: drive inputs, advance the model, check after the edge.
   task automatic step(input bit stb, input logic [7:0] b, input bit rdy);
      logic [7:0] dropped;
      @(negedge clk);
      ps2_ready   = stb;
      ps2_data    = b;
      ascii_ready = rdy;
      if (rdy && exp_q.size() != 0) dropped = exp_q.pop_front();
      if (stb) model_byte(b);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic key(input logic [7:0] b);
      step(1'b1, b, 1'b0);
   endtask

   task automatic pop_expect(input string tag, input logic [7:0] c);
      chk(tag, ascii_data, c);
      step(1'b0, 8'h00, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      ps2_ready   = 1'b0;
      ascii_ready = 1'b0;
      #2 clrn = 1'b0;
      #1;
      chk("rst_valid",    ascii_valid, 0);
      chk("rst_data",     ascii_data,  0);
      chk("rst_shift",    shift_o,     0);
      chk("rst_caps",     caps_o,      0);
      chk("rst_key_down", key_down,    0);
      chk("rst_cur_code", cur_code,    0);
      chk("rst_overflow", overflow,    0);
      model_reset();
      @(negedge clk);
      clrn = 1'b1;
   endtask

   function automatic logic [7:0] pick_byte();
      int r = $urandom_range(0, 99);
      logic [7:0] ext_pool [8] = '{8'h6B, 8'h74, 8'h75, 8'h72, 8'h71, 8'h7D, 8'h14, 8'h12};
      logic [7:0] mod_pool [5] = '{8'h12, 8'h59, 8'h58, 8'h14, 8'h11};
      logic [7:0] misc_pool [9] = '{8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hE1, 8'h04, 8'h05, 8'h06, 8'h0C};
      if (r < 10) return 8'hF0;
      if (r < 15) return 8'hE0;
      if (r < 21) return ext_pool[$urandom_range(0, 7)];
      if (r < 31) return mod_pool[$urandom_range(0, 4)];
      if (r < 36) return misc_pool[$urandom_range(0, 8)];
      if (r < 75) return letter_codes[$urandom_range(0, 25)];
      if (r < 95) return digit_codes[$urandom_range(0, 9)];
      return 8'h29;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      #3;
      chk("init_valid",    ascii_valid, 0);
      chk("init_overflow", overflow,    0);
      @(negedge clk);
      clrn = 1'b1;

      // Make then break of 'A'
      do_reset();
      key(8'h1C);
      chk("t1_head", ascii_data, 8'h61);
      chk("t1_key_down", key_down, 1);
      key(8'hF0); key(8'h1C);
      chk("t1_key_up", key_down, 0);
      chk("t1_cur_code", cur_code, 8'h1C);
      pop_expect("t1_pop", 8'h61);
      chk("t1_empty", ascii_valid, 0);

      // Shift applies to following keys only while held
      do_reset();
      key(8'h12);
      chk("t2_shift_on", shift_o, 1);
      key(8'h16); key(8'hF0); key(8'h16); key(8'hF0); key(8'h12);
      chk("t2_shift_off", shift_o, 0);
      key(8'h16);
      pop_expect("t2_pop_bang", 8'h21);
      pop_expect("t2_pop_one", 8'h31);
      chk("t2_empty", ascii_valid, 0);

      // Caps Lock toggles once despite typematic repeat
      do_reset();
      key(8'h58); key(8'h58); key(8'hF0); key(8'h58);
      chk("t3_caps", caps_o, 1);
      key(8'h1C); key(8'h16);
      pop_expect("t3_pop_A", 8'h41);
      pop_expect("t3_pop_1", 8'h31);
      key(8'h12); key(8'h1C);
      pop_expect("t3_pop_shift_a", 8'h61);

      // Extended keys
      do_reset();
      key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75); key(8'hE0); key(8'h7D);
      chk("t4_shift", shift_o, 0);
      pop_expect("t4_pop_up", 8'h82);
      chk("t4_single", ascii_valid, 0);

      // Overflow with nine pushes into a stalled queue, then full-rate drain
      do_reset();
      for (int i = 0; i < 9; i++) key(8'h1C);
      chk("t5_overflow", overflow, 1);
      for (int i = 0; i < DEPTH; i++) pop_expect("t5_drain", 8'h61);
      chk("t5_drained", ascii_valid, 0);

      // Full queue with simultaneous push and pop drops nothing
      do_reset();
      for (int i = 0; i < DEPTH; i++) key(8'h1C);
      step(1'b1, 8'h16, 1'b1);
      chk("t5b_no_overflow", overflow, 0);
      for (int i = 0; i < DEPTH - 1; i++) pop_expect("t5b_drain_a", 8'h61);
      pop_expect("t5b_drain_1", 8'h31);
      chk("t5b_empty", ascii_valid, 0);

      // Reset discards a pending break prefix
      do_reset();
      key(8'hF0);
      do_reset();
      key(8'h1C);
      chk("t6_after_reset", ascii_data, 8'h61);
      chk("t6_key_down", key_down, 1);

      // Random streams against the model
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 2) != 0, pick_byte(), $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 999) == 0) do_reset();
      end
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
      chk("final_empty", ascii_valid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
